// File: rtl/adc_pkg.sv
// Shared sizes and types for the ADC frame packer and the other PISO feeders.
package adc_pkg;

  localparam int SAMPLE_W          = 16;
  localparam int WORD_W            = 64;
  localparam int WORDS             = 4;
  localparam int SAMPLES_PER_FRAME = 16;
  localparam int CH_W              = $clog2(SAMPLES_PER_FRAME);

  typedef logic [WORD_W-1:0] frame_t [WORDS];

  typedef enum logic {
    HUNT = 1'b0,
    FILL = 1'b1
  } pack_state_t;

  // Bit offset of a channel's sample inside its 64-bit word.
  function automatic logic [5:0] slot_lsb(input logic [CH_W-1:0] ch);
    return {ch[1:0], 4'b0000};
  endfunction

endpackage

// File: rtl/adc_frame_packer_if.sv
// Sample input and frame output bus of the ADC frame packer.
interface adc_frame_packer_if #(
  parameter int CNT_W = 16
);
  import adc_pkg::*;

  logic                SAMPLE_VALID;
  logic [SAMPLE_W-1:0] SAMPLE;
  logic [CH_W-1:0]     SAMPLE_CH;
  logic                CLR_OVF;
  frame_t              DOUT;
  logic                LOAD;
  logic                SYNC_ERR;
  logic                OVERFLOW;
  logic [CNT_W-1:0]    FRAME_CNT;

  modport master (
    output SAMPLE_VALID, SAMPLE, SAMPLE_CH, CLR_OVF,
    input  DOUT, LOAD, SYNC_ERR, OVERFLOW, FRAME_CNT
  );

  modport slave (
    input  SAMPLE_VALID, SAMPLE, SAMPLE_CH, CLR_OVF,
    output DOUT, LOAD, SYNC_ERR, OVERFLOW, FRAME_CNT
  );

endinterface

// File: rtl/adc_load_holdoff.sv
// Drain-time holdoff for a PISO loader: after a load, permit stays low for
// DRAIN_CYCLES clocks while the downstream shifts out.
module adc_load_holdoff #(
  parameter int DRAIN_CYCLES = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic load,
  output logic permit
);

  localparam int HW = 6;

  logic [HW-1:0] cnt_q;

  assign permit = (cnt_q == '0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= HW'(DRAIN_CYCLES);
    end else if (!permit) begin
      cnt_q <= cnt_q - HW'(1);
    end
  end

endmodule

// File: rtl/adc_frame_packer.sv
// Packs channel-tagged ADC samples into 4x64-bit frames and hands them to the
// downstream PISO with a one-cycle LOAD, one frame of buffering and drain holdoff.
module adc_frame_packer
  import adc_pkg::*;
#(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 16
) (
  input logic               CLK,
  input logic               RST,
  adc_frame_packer_if.slave bus
);

  // state | meaning
  // HUNT  | discarding samples until a CH0 sample starts a frame
  // FILL  | assembling a frame, next accepted channel is exp_q

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(SAMPLES_PER_FRAME - 1);

  pack_state_t      state_q;
  logic [CH_W-1:0]  exp_q;
  frame_t           asm_q, asm_nxt, pend_q, dout_q;
  logic             pend_vld_q, load_q, sync_err_q, ovf_q;
  logic [CNT_W-1:0] frame_cnt_q;
  logic             ch_zero, match, mismatch, take, complete;
  logic             permit, issue, park, drop;

  always_comb begin
    asm_nxt = asm_q;
    asm_nxt[bus.SAMPLE_CH[3:2]][slot_lsb(bus.SAMPLE_CH) +: SAMPLE_W] = bus.SAMPLE;
    ch_zero  = (bus.SAMPLE_CH == '0);
    match    = bus.SAMPLE_VALID && (state_q == FILL) && (bus.SAMPLE_CH == exp_q);
    mismatch = bus.SAMPLE_VALID && (state_q == FILL) && (bus.SAMPLE_CH != exp_q);
    take     = match || (bus.SAMPLE_VALID && ch_zero);
    complete = match && (bus.SAMPLE_CH == LAST_CH);
    issue    = permit && (pend_vld_q || complete);
    // A pending frame always goes first; a frame completing alongside it parks.
    park     = complete && (permit ? pend_vld_q : !pend_vld_q);
    drop     = complete && !permit && pend_vld_q;
  end

  adc_load_holdoff #(.DRAIN_CYCLES(DRAIN_CYCLES)) u_holdoff (
    .CLK    (CLK),
    .RST    (RST),
    .load   (issue),
    .permit (permit)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= HUNT;
      exp_q       <= '0;
      asm_q       <= '{default: '0};
      pend_q      <= '{default: '0};
      dout_q      <= '{default: '0};
      pend_vld_q  <= 1'b0;
      load_q      <= 1'b0;
      sync_err_q  <= 1'b0;
      ovf_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      sync_err_q <= mismatch;
      load_q     <= issue;

      if (take) begin
        asm_q <= asm_nxt;
      end

      if (mismatch && !ch_zero) begin
        state_q <= HUNT;
        exp_q   <= '0;
      end else if (take) begin
        state_q <= FILL;
        exp_q   <= bus.SAMPLE_CH + CH_W'(1);
      end

      if (issue) begin
        dout_q      <= pend_vld_q ? pend_q : asm_nxt;
        frame_cnt_q <= frame_cnt_q + CNT_W'(1);
      end

      if (park) begin
        pend_q     <= asm_nxt;
        pend_vld_q <= 1'b1;
      end else if (issue && pend_vld_q) begin
        pend_vld_q <= 1'b0;
      end

      if (drop) begin
        ovf_q <= 1'b1;
      end else if (bus.CLR_OVF) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign bus.DOUT      = dout_q;
  assign bus.LOAD      = load_q;
  assign bus.SYNC_ERR  = sync_err_q;
  assign bus.OVERFLOW  = ovf_q;
  assign bus.FRAME_CNT = frame_cnt_q;

endmodule

// File: tb/tb_adc_frame_packer.sv
// Directed bench for adc_frame_packer: three instances with drain times 4, 20
// and 40 receive identical stimulus; expected values are hand-computed.
module tb_adc_frame_packer;
  import adc_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  adc_frame_packer_if #(.CNT_W(16)) if4 ();
  adc_frame_packer_if #(.CNT_W(16)) if20 ();
  adc_frame_packer_if #(.CNT_W(16)) if40 ();

  adc_frame_packer #(.DRAIN_CYCLES(4),  .CNT_W(16)) u_d4  (.CLK(CLK), .RST(RST), .bus(if4));
  adc_frame_packer #(.DRAIN_CYCLES(20), .CNT_W(16)) u_d20 (.CLK(CLK), .RST(RST), .bus(if20));
  adc_frame_packer #(.DRAIN_CYCLES(40), .CNT_W(16)) u_d40 (.CLK(CLK), .RST(RST), .bus(if40));

  int n_assert = 0;
  int n_fail   = 0;

  // LOAD / SYNC_ERR monitor, sampled on the falling edge
  int cyc = 0;
  int n4 = 0, n20 = 0, n40 = 0, se4 = 0;
  int ld4 [64];
  int ld20[64];
  int ld40[64];

  always @(negedge CLK) begin
    cyc++;
    if (if4.LOAD)  begin if (n4  < 64) ld4[n4]   = cyc; n4++;  end
    if (if20.LOAD) begin if (n20 < 64) ld20[n20] = cyc; n20++; end
    if (if40.LOAD) begin if (n40 < 64) ld40[n40] = cyc; n40++; end
    if (if4.SYNC_ERR) se4++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] ch, input logic [15:0] s);
    if4.SAMPLE_VALID  = v; if4.SAMPLE_CH  = ch; if4.SAMPLE  = s;
    if20.SAMPLE_VALID = v; if20.SAMPLE_CH = ch; if20.SAMPLE = s;
    if40.SAMPLE_VALID = v; if40.SAMPLE_CH = ch; if40.SAMPLE = s;
  endtask

  task automatic clr(input logic c);
    if4.CLR_OVF = c; if20.CLR_OVF = c; if40.CLR_OVF = c;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic stream(input logic [15:0] base, input int first, input int last);
    for (int k = first; k <= last; k++) begin
      drive(1'b1, 4'(k), base + 16'(k));
      step(1);
    end
  endtask

  task automatic do_reset();
    drive(1'b0, 4'd0, 16'd0);
    RST = 1'b1;
    step(2);
    RST = 1'b0;
    step(1);
  endtask

  int b4, b20, b40, s4;

  initial begin
    drive(1'b0, 4'd0, 16'd0);
    clr(1'b0);
    #2 RST = 1'b1;
    step(2);
    check("rst_load",     64'(if4.LOAD),      64'd0);
    check("rst_sync_err", 64'(if4.SYNC_ERR),  64'd0);
    check("rst_overflow", 64'(if4.OVERFLOW),  64'd0);
    check("rst_frame_cnt",64'(if4.FRAME_CNT), 64'd0);
    check("rst_dout0",    if4.DOUT[0],        64'd0);
    check("rst_dout3",    if4.DOUT[3],        64'd0);
    RST = 1'b0;
    step(1);

    // nominal frame
    stream(16'h0000, 0, 15);
    check("nom_no_early_load", 64'(n4),            64'd0);
    check("nom_load",          64'(if4.LOAD),      64'd1);
    check("nom_dout0",         if4.DOUT[0],        64'h0003_0002_0001_0000);
    check("nom_dout1",         if4.DOUT[1],        64'h0007_0006_0005_0004);
    check("nom_dout3",         if4.DOUT[3],        64'h000F_000E_000D_000C);
    check("nom_frame_cnt",     64'(if4.FRAME_CNT), 64'd1);
    drive(1'b0, 4'd0, 16'd0);
    step(1);
    check("nom_load_single",   64'(if4.LOAD),      64'd0);
    step(50);

    // back-to-back frames
    do_reset();
    b4 = n4; b20 = n20;
    stream(16'h1000, 0, 15);
    stream(16'h2000, 0, 15);
    drive(1'b0, 4'd0, 16'd0);
    step(30);
    check("b2b_d20_loads",     64'(n20 - b20),                64'd2);
    check("b2b_d20_gap",       64'(ld20[b20+1] - ld20[b20]),  64'd21);
    check("b2b_d20_dout0",     if20.DOUT[0],                  64'h2003_2002_2001_2000);
    check("b2b_d20_overflow",  64'(if20.OVERFLOW),            64'd0);
    check("b2b_d20_frame_cnt", 64'(if20.FRAME_CNT),           64'd2);
    check("b2b_d4_gap",        64'(ld4[b4+1] - ld4[b4]),      64'd16);

    // overflow: third frame lands while pending is full; clear in same cycle loses
    do_reset();
    b20 = n20; b40 = n40;
    stream(16'h3000, 0, 15);
    stream(16'h4000, 0, 15);
    stream(16'h5000, 0, 14);
    clr(1'b1);
    drive(1'b1, 4'd15, 16'h500F);
    step(1);
    clr(1'b0);
    check("ovf_set_wins",      64'(if40.OVERFLOW),            64'd1);
    drive(1'b0, 4'd0, 16'd0);
    step(60);
    check("ovf_d40_loads",     64'(n40 - b40),                64'd2);
    check("ovf_d40_gap",       64'(ld40[b40+1] - ld40[b40]),  64'd41);
    check("ovf_d40_dout3",     if40.DOUT[3],                  64'h400F_400E_400D_400C);
    check("ovf_d40_frame_cnt", 64'(if40.FRAME_CNT),           64'd2);
    check("ovf_d40_sticky",    64'(if40.OVERFLOW),            64'd1);
    check("ovf_d20_loads",     64'(n20 - b20),                64'd3);
    check("ovf_d20_no_ovf",    64'(if20.OVERFLOW),            64'd0);
    check("ovf_d20_dout0",     if20.DOUT[0],                  64'h5003_5002_5001_5000);
    clr(1'b1);
    step(1);
    clr(1'b0);
    check("ovf_cleared",       64'(if40.OVERFLOW),            64'd0);

    // misalignment, then clean frame, then mid-frame CH0 restart
    do_reset();
    b4 = n4; s4 = se4;
    stream(16'h6000, 0, 5);
    drive(1'b1, 4'd9, 16'h6009);
    step(1);
    check("mis_sync_err",      64'(if4.SYNC_ERR),             64'd1);
    drive(1'b0, 4'd0, 16'd0);
    step(1);
    check("mis_sync_pulse",    64'(if4.SYNC_ERR),             64'd0);
    check("mis_no_load",       64'(n4 - b4),                  64'd0);
    stream(16'h7000, 0, 15);
    check("mis_recover_load",  64'(if4.LOAD),                 64'd1);
    check("mis_recover_dout2", if4.DOUT[2],                   64'h700B_700A_7009_7008);
    drive(1'b0, 4'd0, 16'd0);
    step(10);
    stream(16'h8000, 0, 7);
    stream(16'h9000, 0, 15);
    check("restart_load",      64'(if4.LOAD),                 64'd1);
    check("restart_dout0",     if4.DOUT[0],                   64'h9003_9002_9001_9000);
    check("restart_dout3",     if4.DOUT[3],                   64'h900F_900E_900D_900C);
    drive(1'b0, 4'd0, 16'd0);
    step(2);
    check("restart_sync_errs", 64'(se4 - s4),                 64'd2);
    check("restart_loads",     64'(n4 - b4),                  64'd2);

    // startup in HUNT
    do_reset();
    b4 = n4; s4 = se4;
    stream(16'hA000, 7, 15);
    stream(16'hB000, 0, 15);
    check("hunt_load",         64'(if4.LOAD),                 64'd1);
    drive(1'b0, 4'd0, 16'd0);
    step(3);
    check("hunt_no_sync_err",  64'(se4 - s4),                 64'd0);
    check("hunt_one_load",     64'(n4 - b4),                  64'd1);
    check("hunt_dout1",        if4.DOUT[1],                   64'hB007_B006_B005_B004);

    // async reset mid-frame with a frame pending in the 40-cycle instance
    do_reset();
    stream(16'hC000, 0, 15);
    stream(16'hC100, 0, 15);
    stream(16'hC200, 0, 9);
    drive(1'b0, 4'd0, 16'd0);
    #2 RST = 1'b1;
    #1;
    check("arst_d4_dout0",     if4.DOUT[0],                   64'd0);
    check("arst_d4_frame_cnt", 64'(if4.FRAME_CNT),            64'd0);
    check("arst_d40_dout3",    if40.DOUT[3],                  64'd0);
    check("arst_d40_frame_cnt",64'(if40.FRAME_CNT),           64'd0);
    #2 RST = 1'b0;
    step(1);
    b4 = n4; b40 = n40;
    stream(16'hD000, 10, 15);
    drive(1'b0, 4'd0, 16'd0);
    step(60);
    check("arst_d4_no_load",   64'(n4 - b4),                  64'd0);
    check("arst_d40_no_load",  64'(n40 - b40),                64'd0);
    stream(16'hE000, 0, 15);
    check("arst_d4_new_load",  64'(if4.LOAD),                 64'd1);
    check("arst_d40_new_load", 64'(if40.LOAD),                64'd1);
    check("arst_d40_dout0",    if40.DOUT[0],                  64'hE003_E002_E001_E000);
    check("arst_d40_frame_cnt",64'(if40.FRAME_CNT),           64'd1);
    drive(1'b0, 4'd0, 16'd0);
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_frame_packer.md
Name: adc_frame_packer

Overview:
- Upstream stage of the 4x64 parallel-in/serial-out shift register in the ADC acquisition path.
- Collects a stream of 16-bit ADC samples, tagged with channel index 0..15, into one 256-bit frame of four 64-bit words.
- Presents the frame on a parallel bus with a one-cycle LOAD strobe.
- Enforces the downstream drain time between loads, holds one pending frame, and flags channel misalignment and overflow.

Parameters:
- DRAIN_CYCLES, 4: clocks the downstream needs after a LOAD to shift out 4 words. Legal range 4..63.
- CNT_W, 16: width of the frame counter.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- SAMPLE_VALID  in  1  SAMPLE/SAMPLE_CH valid this cycle.
- SAMPLE  in  16  ADC sample.
- SAMPLE_CH  in  4  channel index of SAMPLE.
- CLR_OVF  in  1  synchronous clear of OVERFLOW.
- DOUT  out  [63:0] x [3:0] (unpacked, index 0..3)  frame words; word 0 is shifted out first downstream.
- LOAD  out  1  one-cycle strobe: DOUT holds a new frame.
- SYNC_ERR  out  1  one-cycle pulse: channel index mismatch.
- OVERFLOW  out  1  sticky: a completed frame was dropped.
- FRAME_CNT  out  CNT_W  frames issued via LOAD, wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, RST high):
  - all outputs 0, DOUT all words 0.
  - expected channel = 0, assembly empty, pending empty, holdoff counter 0, state HUNT.
- Packing: sample with channel k goes to DOUT[k/4] bits [16*(k%4)+15 : 16*(k%4)].
- States:
  - HUNT: ignore samples until SAMPLE_VALID with SAMPLE_CH==0. That sample is stored as slot 0, expected = 1, go to FILL. No SYNC_ERR in HUNT.
  - FILL, SAMPLE_VALID with SAMPLE_CH == expected: store the sample, increment expected. When the stored channel is 15, the frame is complete, expected = 0, and the state stays FILL.
  - FILL, SAMPLE_VALID with SAMPLE_CH != expected:
    - pulse SYNC_ERR next cycle and discard the partial frame.
    - if SAMPLE_CH==0, store it as slot 0 and set expected = 1 (stay in FILL); otherwise go to HUNT.
  - SAMPLE_VALID low: no change.
- Frame complete, issue path:
  - Completion means the channel-15 sample is registered at edge N.
  - If a LOAD is permitted (see holdoff), DOUT updates and LOAD is high in cycle N+1. Latency is 1 clock.
  - Otherwise the frame moves to the pending buffer.
  - If pending is already full, the new frame is dropped, OVERFLOW is set, and the pending frame is kept.
- Holdoff:
  - Two LOAD pulses are never less than DRAIN_CYCLES+1 clocks apart.
  - The counter is set to DRAIN_CYCLES in the LOAD cycle and decrements to 0. A LOAD is permitted in a cycle whose counter value entering that cycle is 0.
  - A pending frame issues at the first permitted cycle; the pending buffer then empties.
  - If a frame completes in the same cycle that pending issues, the new frame goes into pending. No overflow.
- DOUT is stable between LOAD pulses.
- LOAD is never high for two consecutive cycles.
- FRAME_CNT increments in each LOAD cycle.
- OVERFLOW is cleared by CLR_OVF. If set and clear occur in the same cycle, set wins.
- Reset mid-frame or with a frame pending: everything is discarded, and no LOAD is issued after reset release until a full new frame arrives.

Decomposition:
- Package adc_pkg:
  - SAMPLE_W=16, WORD_W=64, WORDS=4, SAMPLES_PER_FRAME=16.
  - typedef frame_t (logic [63:0] array [3:0]).
  - enum pack_state_t {HUNT, FILL}.
- Sub-module adc_load_holdoff: counter plus permit flag. It is small but reused by other PISO feeders.

Test Plan:
- Nominal frame: samples 16'h0000+k on CH k=0..15, one per cycle. Expect:
  - LOAD exactly one cycle after CH15.
  - DOUT[0] = 64'h0003_0002_0001_0000.
  - DOUT[3] = 64'h000F_000E_000D_000C.
  - FRAME_CNT = 1.
- Back-to-back frames with DRAIN_CYCLES=20, continuous valid:
  - second frame goes pending, and its LOAD is exactly 21 clocks after the first.
  - OVERFLOW stays 0.
- Overflow with DRAIN_CYCLES=40, three continuous frames. Expect:
  - frames 1 and 2 issued.
  - frame 3 dropped, OVERFLOW=1.
  - CLR_OVF clears it.
- Misalignment: CH 0..5 then CH 9:
  - expect one SYNC_ERR pulse and no LOAD.
  - after that, a valid CH0..15 sequence produces a correct frame.
  - a mid-frame CH0 restart also produces a correct frame.
- Startup in HUNT: stream beginning at CH 7..15 then 0..15. Expect no SYNC_ERR and exactly one LOAD, with the second group's data.
- Async reset asserted mid-frame and with a frame pending. Expect:
  - outputs 0 immediately.
  - no LOAD after release until 16 new aligned samples arrive.
